// File: rtl/game_sequencer.sv
// game_sequencer: turn controller for the connect-four core.
// Wipes the board, takes column drops, finds the lowest empty row through the
// shared board read port, writes the piece and then hands the read port to the
// victory checker. It tracks the player to move, the move count and the
// win/draw/timeout status of the game.
module game_sequencer #(
  parameter int ROWS          = 6,
  parameter int COLS          = 7,
  parameter int CHECK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  output logic       drop_ready,
  output logic       move_rejected,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  input  logic [1:0] rd_data,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [1:0] wr_data,
  output logic       vc_start,
  output logic [2:0] vc_move_row,
  output logic [2:0] vc_move_col,
  input  logic [2:0] vc_read_row,
  input  logic [2:0] vc_read_col,
  input  logic       vc_done,
  input  logic [1:0] vc_winner,
  output logic [1:0] current_player,
  output logic [5:0] move_count,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw,
  output logic       check_error
);

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);
  localparam logic [3:0] NUM_COLS = 4'(COLS);
  localparam logic [5:0] CELLS    = 6'(ROWS * COLS);
  localparam logic [7:0] TMO_LAST = 8'(CHECK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_SCAN,
    S_WRITE,
    S_START,
    S_WAIT,
    S_OVER
  } state_t;

  state_t     state_reg, state_next;
  // row/col counters are shared: wipe address in CLEAR, scan/target cell otherwise
  logic [2:0] row_reg, row_next;
  logic [2:0] col_reg, col_next;
  logic [1:0] player_reg, player_next;
  logic [5:0] count_reg, count_next;
  logic [1:0] winner_reg, winner_next;
  logic       draw_reg, draw_next;
  logic       err_reg, err_next;
  logic       rej_reg, rej_next;
  logic [7:0] tmo_reg, tmo_next;
  logic       wipe;

  // State and status registers; reset drops straight back into a board wipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_CLEAR;
      row_reg    <= 3'd0;
      col_reg    <= 3'd0;
      player_reg <= 2'b01;
      count_reg  <= 6'd0;
      winner_reg <= 2'b00;
      draw_reg   <= 1'b0;
      err_reg    <= 1'b0;
      rej_reg    <= 1'b0;
      tmo_reg    <= 8'd0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      col_reg    <= col_next;
      player_reg <= player_next;
      count_reg  <= count_next;
      winner_reg <= winner_next;
      draw_reg   <= draw_next;
      err_reg    <= err_next;
      rej_reg    <= rej_next;
      tmo_reg    <= tmo_next;
    end
  end

  // Next-state logic: sequencing of wipe, scan, write and victory check.
  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    player_next = player_reg;
    count_next  = count_reg;
    winner_next = winner_reg;
    draw_next   = draw_reg;
    err_next    = err_reg;
    rej_next    = 1'b0;
    tmo_next    = tmo_reg;
    wipe        = 1'b0;

    case (state_reg)
      S_CLEAR: begin
        // row-major walk: column advances fastest
        if (col_reg == LAST_COL) begin
          col_next = 3'd0;
          if (row_reg == LAST_ROW) begin
            row_next   = 3'd0;
            state_next = S_IDLE;
          end else begin
            row_next = row_reg + 3'd1;
          end
        end else begin
          col_next = col_reg + 3'd1;
        end
      end

      S_IDLE: begin
        // a new game request takes precedence over a simultaneous drop
        if (new_game) begin
          wipe = 1'b1;
        end else if (drop_valid) begin
          if ({1'b0, drop_col} >= NUM_COLS) begin
            rej_next = 1'b1;
          end else begin
            col_next   = drop_col;
            row_next   = 3'd0;
            state_next = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        // any non-empty code (including the unused 11) counts as occupied
        if (rd_data == 2'b00) begin
          state_next = S_WRITE;
        end else if (row_reg < LAST_ROW) begin
          row_next = row_reg + 3'd1;
        end else begin
          rej_next   = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_WRITE: begin
        count_next = count_reg + 6'd1;
        state_next = S_START;
      end

      S_START: begin
        tmo_next   = 8'd0;
        state_next = S_WAIT;
      end

      S_WAIT: begin
        // a win on the board-filling move is reported as a win, not a draw
        if (vc_done) begin
          if (vc_winner != 2'b00) begin
            winner_next = vc_winner;
            state_next  = S_OVER;
          end else if (count_reg == CELLS) begin
            draw_next  = 1'b1;
            state_next = S_OVER;
          end else begin
            player_next = player_reg ^ 2'b11;
            state_next  = S_IDLE;
          end
        end else if (tmo_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = S_OVER;
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end

      S_OVER: begin
        if (new_game) begin
          wipe = 1'b1;
        end
      end

      default: begin
        state_next = S_CLEAR;
        row_next   = 3'd0;
        col_next   = 3'd0;
      end
    endcase

    // starting a new game resets every piece of game status
    if (wipe) begin
      state_next  = S_CLEAR;
      row_next    = 3'd0;
      col_next    = 3'd0;
      player_next = 2'b01;
      count_next  = 6'd0;
      winner_next = 2'b00;
      draw_next   = 1'b0;
      err_next    = 1'b0;
      tmo_next    = 8'd0;
    end
  end

  // Output decode: write port, read-port ownership and handshakes.
  always_comb begin
    drop_ready = (state_reg == S_IDLE);
    wr_en      = (state_reg == S_CLEAR) || (state_reg == S_WRITE);
    wr_row     = wr_en ? row_reg : 3'd0;
    wr_col     = wr_en ? col_reg : 3'd0;
    wr_data    = (state_reg == S_WRITE) ? player_reg : 2'b00;
    vc_start   = (state_reg == S_START);
    rd_row     = 3'd0;
    rd_col     = 3'd0;
    if (state_reg == S_SCAN) begin
      rd_row = row_reg;
      rd_col = col_reg;
    end else if ((state_reg == S_START) || (state_reg == S_WAIT)) begin
      rd_row = vc_read_row;
      rd_col = vc_read_col;
    end
  end

  // row/col hold still from START until the checker finishes
  assign vc_move_row    = row_reg;
  assign vc_move_col    = col_reg;
  assign move_rejected  = rej_reg;
  assign current_player = player_reg;
  assign move_count     = count_reg;
  assign game_over      = (state_reg == S_OVER);
  assign winner         = winner_reg;
  assign draw           = draw_reg;
  assign check_error    = err_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed bench for game_sequencer with a board memory
// model and a hand-driven victory checker.
module tb_game_sequencer;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_game;
  logic       drop_valid;
  logic [2:0] drop_col;
  logic       drop_ready;
  logic       move_rejected;
  logic [2:0] rd_row, rd_col;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [2:0] wr_row, wr_col;
  logic [1:0] wr_data;
  logic       vc_start;
  logic [2:0] vc_move_row, vc_move_col;
  logic [2:0] vc_read_row, vc_read_col;
  logic       vc_done;
  logic [1:0] vc_winner;
  logic [1:0] current_player;
  logic [5:0] move_count;
  logic       game_over;
  logic [1:0] winner;
  logic       draw;
  logic       check_error;

  logic [1:0] board [ROWS][COLS];
  logic       scramble;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_sequencer #(.ROWS(ROWS), .COLS(COLS), .CHECK_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .drop_valid(drop_valid), .drop_col(drop_col), .drop_ready(drop_ready),
    .move_rejected(move_rejected), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .vc_start(vc_start), .vc_move_row(vc_move_row),
    .vc_move_col(vc_move_col), .vc_read_row(vc_read_row),
    .vc_read_col(vc_read_col), .vc_done(vc_done), .vc_winner(vc_winner),
    .current_player(current_player), .move_count(move_count),
    .game_over(game_over), .winner(winner), .draw(draw),
    .check_error(check_error)
  );

  // Board memory model: combinational read, write on the clock edge.
  assign rd_data = (int'(rd_row) < ROWS && int'(rd_col) < COLS) ?
                   board[int'(rd_row)][int'(rd_col)] : 2'b00;

  always @(posedge clk) begin
    if (scramble) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board[r][c] <= 2'b11;
    end else if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS) begin
      board[int'(wr_row)][int'(wr_col)] <= wr_data;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT in the first CLEAR cycle.
  task automatic expect_clear(input string tag);
    int n;
    int bad_order;
    int dirty;
    n = 0;
    bad_order = 0;
    dirty = 0;
    for (int i = 0; i < 100 && !drop_ready; i++) begin
      if (wr_en) begin
        if (wr_data != 2'b00 || int'(wr_row) * COLS + int'(wr_col) != n)
          bad_order++;
        n++;
      end
      @(negedge clk);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (board[r][c] != 2'b00) dirty++;
    chk({tag, "_cycles"}, n, ROWS * COLS);
    chk({tag, "_order"}, bad_order, 0);
    chk({tag, "_dirty"}, dirty, 0);
    chk({tag, "_ready"}, int'(drop_ready), 1);
    chk({tag, "_player"}, int'(current_player), 1);
    chk({tag, "_count"}, int'(move_count), 0);
    chk({tag, "_winner"}, int'(winner), 0);
    chk({tag, "_flags"}, int'({game_over, draw, check_error}), 0);
    $display("clear %s: %0d write cycles", tag, n);
  endtask

  task automatic start_new_game(input string tag);
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    @(negedge clk);
    new_game = 1'b0;
    expect_clear(tag);
  endtask

  // One drop from IDLE. exp_row < 0 means the drop must be rejected.
  // tmo = 1 withholds vc_done so the checker timeout fires.
  task automatic move(input int col, input int exp_row, input logic [1:0] vcw,
                      input bit tmo);
    logic [1:0] pl;
    int cnt0;
    int scans;
    int exp_scans;
    int n;
    bit got_wr;
    bit got_rej;
    pl = current_player;
    cnt0 = int'(move_count);
    exp_scans = (col >= COLS) ? 0 : (exp_row < 0) ? ROWS : exp_row + 1;
    scans = 0;
    got_wr = 1'b0;
    got_rej = 1'b0;
    drop_valid = 1'b1;
    drop_col = 3'(col);
    @(posedge clk);
    @(negedge clk);
    drop_valid = 1'b0;
    for (int i = 0; i < 20 && !got_wr && !got_rej; i++) begin
      if (wr_en) begin
        got_wr = 1'b1;
      end else if (move_rejected) begin
        got_rej = 1'b1;
      end else begin
        if (int'(rd_row) != scans || int'(rd_col) != col) errors += 0;
        chk("scan_addr", int'({rd_row, rd_col}), scans * 8 + col);
        scans++;
        @(negedge clk);
      end
    end
    chk("scan_len", scans, exp_scans);
    if (exp_row < 0) begin
      chk("rej_seen", int'(got_rej), 1);
      chk("rej_rd", int'({rd_row, rd_col}), 0);
      chk("rej_ready", int'(drop_ready), 1);
      chk("rej_count", int'(move_count), cnt0);
      chk("rej_player", int'(current_player), int'(pl));
      @(negedge clk);
      chk("rej_pulse", int'(move_rejected), 0);
      $display("move col=%0d player=%0d scans=%0d rejected", col, pl, scans);
      return;
    end
    chk("wr_seen", int'(got_wr), 1);
    chk("wr_addr", int'({wr_row, wr_col}), exp_row * 8 + col);
    chk("wr_data", int'(wr_data), int'(pl));
    vc_read_row = 3'd5;
    vc_read_col = 3'd2;
    @(negedge clk);
    chk("vc_start", int'(vc_start), 1);
    chk("vc_move", int'({vc_move_row, vc_move_col}), exp_row * 8 + col);
    chk("count_inc", int'(move_count), cnt0 + 1);
    chk("rd_mux", int'({rd_row, rd_col}), 5 * 8 + 2);
    if (tmo) begin
      n = 0;
      while (!check_error && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("tmo_cycles", n, 256);
      chk("tmo_over", int'(game_over), 1);
      chk("tmo_winner", int'({winner, draw}), 0);
      vc_read_row = 3'd0;
      vc_read_col = 3'd0;
      $display("move col=%0d player=%0d timeout after %0d cycles", col, pl, n);
      return;
    end
    @(negedge clk);
    chk("vc_pulse", int'(vc_start), 0);
    chk("vc_stable", int'({vc_move_row, vc_move_col}), exp_row * 8 + col);
    vc_done = 1'b1;
    vc_winner = vcw;
    @(posedge clk);
    @(negedge clk);
    vc_done = 1'b0;
    vc_winner = 2'b00;
    vc_read_row = 3'd0;
    vc_read_col = 3'd0;
    if (vcw != 2'b00) begin
      chk("win_over", int'(game_over), 1);
      chk("win_who", int'(winner), int'(vcw));
      chk("win_nodraw", int'(draw), 0);
      chk("win_ready", int'(drop_ready), 0);
    end else if (cnt0 + 1 == ROWS * COLS) begin
      chk("draw_over", int'(game_over), 1);
      chk("draw_flag", int'(draw), 1);
      chk("draw_winner", int'(winner), 0);
    end else begin
      chk("next_player", int'(current_player), int'(pl ^ 2'b11));
      chk("next_ready", int'(drop_ready), 1);
      chk("next_over", int'(game_over), 0);
    end
    $display("move col=%0d row=%0d player=%0d scans=%0d count=%0d over=%0d",
             col, exp_row, pl, scans, move_count, game_over);
  endtask

  initial begin
    int stray;
    rst_n = 1'b0;
    new_game = 1'b0;
    drop_valid = 1'b0;
    drop_col = 3'd0;
    vc_read_row = 3'd0;
    vc_read_col = 3'd0;
    vc_done = 1'b0;
    vc_winner = 2'b00;
    scramble = 1'b1;
    repeat (2) @(negedge clk);
    scramble = 1'b0;
    repeat (2) @(negedge clk);

    // T1: reset state, then full board wipe
    chk("rst_player", int'(current_player), 1);
    chk("rst_count", int'(move_count), 0);
    chk("rst_flags", int'({game_over, draw, check_error, move_rejected, vc_start}), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_ready", int'(drop_ready), 0);
    rst_n = 1'b1;
    expect_clear("t1");

    // T2: first drop on an empty board
    @(negedge clk);
    move(3, 0, 2'b00, 1'b0);

    // T3: fill column 0, then one more drop into it is rejected
    for (int r = 0; r < ROWS; r++) move(0, r, 2'b00, 1'b0);
    chk("t3_count", int'(move_count), 7);
    move(0, -1, 2'b00, 1'b0);

    // T4: column out of range
    move(7, -1, 2'b00, 1'b0);

    // vc_done while idle must not end the game
    vc_done = 1'b1;
    vc_winner = 2'b01;
    @(negedge clk);
    vc_done = 1'b0;
    vc_winner = 2'b00;
    @(negedge clk);
    chk("stray_done", int'({game_over, winner}), 0);
    chk("stray_ready", int'(drop_ready), 1);

    // T5: player 2 wins, drops are ignored, new game wipes
    move(1, 0, 2'b10, 1'b0);
    stray = 0;
    drop_valid = 1'b1;
    drop_col = 3'd4;
    repeat (4) begin
      @(negedge clk);
      if (wr_en || drop_ready || move_rejected || !game_over) stray++;
    end
    drop_valid = 1'b0;
    chk("over_ignore", stray, 0);
    start_new_game("t5");

    // T6a: fill the board with no winner -> draw
    @(negedge clk);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) move(c, r, 2'b00, 1'b0);
    chk("t6_count", int'(move_count), ROWS * COLS);
    start_new_game("t6a");

    // T6b: last move fills the board and wins -> win beats draw
    @(negedge clk);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        move(c, r, (c == COLS - 1 && r == ROWS - 1) ? 2'b10 : 2'b00, 1'b0);
    start_new_game("t6b");

    // T6c: checker never answers -> check_error, cleared by new game
    @(negedge clk);
    move(3, 0, 2'b00, 1'b1);
    start_new_game("t6c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
